// File: rtl/exu_bjp_unit_pkg.sv
// Shared definitions for the branch/jump execution unit: decode-info field
// indices, FSM state type and a one-hot helper.
package exu_bjp_unit_pkg;

    localparam int unsigned DECINFO_BJP_JAL   = 0;
    localparam int unsigned DECINFO_BJP_JALR  = 1;
    localparam int unsigned DECINFO_BJP_BEQ   = 2;
    localparam int unsigned DECINFO_BJP_BNE   = 3;
    localparam int unsigned DECINFO_BJP_BLT   = 4;
    localparam int unsigned DECINFO_BJP_BGE   = 5;
    localparam int unsigned DECINFO_BJP_BLTU  = 6;
    localparam int unsigned DECINFO_BJP_BGEU  = 7;
    localparam int unsigned DECINFO_BJP_BPRDT = 8;
    localparam int unsigned DECINFO_BJP_WIDTH = 9;
    localparam int unsigned DECINFO_BJP_OPS   = 8;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } bjp_state_e;

    function automatic logic is_onehot_op(input logic [DECINFO_BJP_OPS-1:0] op);
        return (op != '0) && ((op & (op - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/exu_bjp_cmp.sv
// Combinational branch comparator: decodes the op field and resolves taken.
// Malformed op encodings (zero or multi-hot) decode to nothing and are never taken.
module exu_bjp_cmp
    import exu_bjp_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]              rs1,
    input  logic [XLEN-1:0]              rs2,
    input  logic [DECINFO_BJP_WIDTH-1:0] info,
    output logic                         op_ok,
    output logic                         is_jal,
    output logic                         is_jalr,
    output logic                         is_branch,
    output logic                         taken
);

    logic [DECINFO_BJP_OPS-1:0] op;
    logic                       eq;
    logic                       lt;
    logic                       ltu;

    assign op    = info[DECINFO_BJP_OPS-1:0];
    assign op_ok = is_onehot_op(op);
    assign eq    = (rs1 == rs2);
    assign lt    = ($signed(rs1) < $signed(rs2));
    assign ltu   = (rs1 < rs2);

    assign is_jal    = op_ok & op[DECINFO_BJP_JAL];
    assign is_jalr   = op_ok & op[DECINFO_BJP_JALR];
    assign is_branch = op_ok & ~(op[DECINFO_BJP_JAL] | op[DECINFO_BJP_JALR]);

    always_comb begin
        taken = 1'b0;
        if (op_ok) begin
            unique case (1'b1)
                op[DECINFO_BJP_JAL]:  taken = 1'b1;
                op[DECINFO_BJP_JALR]: taken = 1'b1;
                op[DECINFO_BJP_BEQ]:  taken = eq;
                op[DECINFO_BJP_BNE]:  taken = ~eq;
                op[DECINFO_BJP_BLT]:  taken = lt;
                op[DECINFO_BJP_BGE]:  taken = ~lt;
                op[DECINFO_BJP_BLTU]: taken = ltu;
                op[DECINFO_BJP_BGEU]: taken = ~ltu;
                default:              taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/exu_bjp_unit.sv
// Registered branch/jump execution unit: resolves target and link, checks the
// static prediction, raises a flush on mispredict and counts mispredicts.
module exu_bjp_unit
    import exu_bjp_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bjp_i_valid,
    output logic                         bjp_i_ready,
    input  logic [XLEN-1:0]              bjp_i_rs1,
    input  logic [XLEN-1:0]              bjp_i_rs2,
    input  logic [XLEN-1:0]              bjp_i_imm,
    input  logic [PC_SIZE-1:0]           bjp_i_pc,
    input  logic [DECINFO_BJP_WIDTH-1:0] bjp_i_info,
    output logic                         bjp_o_valid,
    input  logic                         bjp_o_ready,
    output logic [XLEN-1:0]              bjp_o_wbck_wdat,
    output logic                         bjp_o_wbck_en,
    output logic                         bjp_o_taken,
    output logic [PC_SIZE-1:0]           bjp_o_target,
    output logic                         bjp_o_mispred,
    output logic                         flush_req,
    output logic [PC_SIZE-1:0]           flush_pc,
    input  logic                         flush_ack,
    output logic [CNT_W-1:0]             mispred_cnt
);

    logic op_ok;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic cmp_taken;

    exu_bjp_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rs1       (bjp_i_rs1),
        .rs2       (bjp_i_rs2),
        .info      (bjp_i_info),
        .op_ok     (op_ok),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_branch (is_branch),
        .taken     (cmp_taken)
    );

    logic [PC_SIZE-1:0] pc_plus4;
    logic [PC_SIZE-1:0] pc_plus_imm;
    logic [XLEN-1:0]    jalr_sum;
    logic [PC_SIZE-1:0] jalr_tgt;
    logic [PC_SIZE-1:0] res_target;
    logic [XLEN-1:0]    res_wdat;
    logic               res_wen;
    logic               res_mispred;

    assign pc_plus4    = bjp_i_pc + PC_SIZE'(4);
    assign pc_plus_imm = bjp_i_pc + bjp_i_imm[PC_SIZE-1:0];
    assign jalr_sum    = bjp_i_rs1 + bjp_i_imm;
    assign jalr_tgt    = jalr_sum[PC_SIZE-1:0] & ~PC_SIZE'(1);

    always_comb begin
        res_target = pc_plus4;
        if (cmp_taken) begin
            res_target = is_jalr ? jalr_tgt : pc_plus_imm;
        end
    end

    assign res_wen     = is_jal | is_jalr;
    assign res_wdat    = res_wen ? XLEN'(pc_plus4) : '0;
    // JAL is redirected by the IFU itself, so only JALR and wrong branch guesses flush.
    assign res_mispred = is_jalr | (is_branch & (cmp_taken ^ bjp_i_info[DECINFO_BJP_BPRDT]));

    bjp_state_e         state_q, state_d;
    logic               o_valid_q, o_valid_d;
    logic [XLEN-1:0]    wdat_q;
    logic               wen_q;
    logic               taken_q;
    logic [PC_SIZE-1:0] target_q;
    logic               mispred_q;
    logic               flush_req_q, flush_req_d;
    logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic i_accept;
    logic o_hs;
    logic enter_flush;
    logic leave_flush;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (o_hs && mispred_q) state_d = StFlush;
            StFlush: if (flush_ack) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bjp_i_ready = (state_q == StRun) && !flush_req_q && (!o_valid_q || bjp_o_ready);
        enter_flush = (state_q == StRun) && o_hs && mispred_q;
        leave_flush = (state_q == StFlush) && flush_ack;
    end

    assign i_accept = bjp_i_valid & bjp_i_ready;
    assign o_hs     = o_valid_q & bjp_o_ready;

    always_comb begin
        o_valid_d   = o_valid_q;
        flush_req_d = flush_req_q;
        flush_pc_d  = flush_pc_q;
        cnt_d       = cnt_q;
        if (i_accept) begin
            o_valid_d = 1'b1;
        end else if (o_hs) begin
            o_valid_d = 1'b0;
        end
        if (enter_flush) begin
            flush_req_d = 1'b1;
            flush_pc_d  = target_q;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (leave_flush) begin
            flush_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q   <= 1'b0;
            wdat_q      <= '0;
            wen_q       <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            mispred_q   <= 1'b0;
            flush_req_q <= 1'b0;
            flush_pc_q  <= '0;
            cnt_q       <= '0;
        end else begin
            o_valid_q   <= o_valid_d;
            flush_req_q <= flush_req_d;
            flush_pc_q  <= flush_pc_d;
            cnt_q       <= cnt_d;
            if (i_accept) begin
                wdat_q    <= res_wdat;
                wen_q     <= res_wen;
                taken_q   <= cmp_taken;
                target_q  <= res_target;
                mispred_q <= res_mispred;
            end
        end
    end

    assign bjp_o_valid     = o_valid_q;
    assign bjp_o_wbck_wdat = wdat_q;
    assign bjp_o_wbck_en   = wen_q;
    assign bjp_o_taken     = taken_q;
    assign bjp_o_target    = target_q;
    assign bjp_o_mispred   = mispred_q;
    assign flush_req       = flush_req_q;
    assign flush_pc        = flush_pc_q;
    assign mispred_cnt     = cnt_q;

endmodule

// File: tb/tb_exu_bjp_unit.sv
// Self-checking bench for exu_bjp_unit: directed cases, a saturation run and
// randomized traffic, all compared every cycle against a behavioural model.
module tb_exu_bjp_unit;
    import exu_bjp_unit_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_SIZE = 32;
    localparam int unsigned CNT_W   = 8;  // narrow so saturation is reachable quickly

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         bjp_i_valid;
    logic                         bjp_i_ready;
    logic [XLEN-1:0]              bjp_i_rs1;
    logic [XLEN-1:0]              bjp_i_rs2;
    logic [XLEN-1:0]              bjp_i_imm;
    logic [PC_SIZE-1:0]           bjp_i_pc;
    logic [DECINFO_BJP_WIDTH-1:0] bjp_i_info;
    logic                         bjp_o_valid;
    logic                         bjp_o_ready;
    logic [XLEN-1:0]              bjp_o_wbck_wdat;
    logic                         bjp_o_wbck_en;
    logic                         bjp_o_taken;
    logic [PC_SIZE-1:0]           bjp_o_target;
    logic                         bjp_o_mispred;
    logic                         flush_req;
    logic [PC_SIZE-1:0]           flush_pc;
    logic                         flush_ack;
    logic [CNT_W-1:0]             mispred_cnt;

    exu_bjp_unit #(
        .XLEN(XLEN),
        .PC_SIZE(PC_SIZE),
        .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bjp_i_valid     (bjp_i_valid),
        .bjp_i_ready     (bjp_i_ready),
        .bjp_i_rs1       (bjp_i_rs1),
        .bjp_i_rs2       (bjp_i_rs2),
        .bjp_i_imm       (bjp_i_imm),
        .bjp_i_pc        (bjp_i_pc),
        .bjp_i_info      (bjp_i_info),
        .bjp_o_valid     (bjp_o_valid),
        .bjp_o_ready     (bjp_o_ready),
        .bjp_o_wbck_wdat (bjp_o_wbck_wdat),
        .bjp_o_wbck_en   (bjp_o_wbck_en),
        .bjp_o_taken     (bjp_o_taken),
        .bjp_o_target    (bjp_o_target),
        .bjp_o_mispred   (bjp_o_mispred),
        .flush_req       (flush_req),
        .flush_pc        (flush_pc),
        .flush_ack       (flush_ack),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic               wen;
        logic               taken;
        logic [PC_SIZE-1:0] target;
        logic               mispred;
    } res_t;

    int total = 0;
    int bad   = 0;

    // Model state
    bit               m_flush;
    bit               m_ov;
    res_t             m_res;
    bit               m_freq;
    logic [PC_SIZE-1:0] m_fpc;
    int unsigned      m_cnt;

    localparam logic [8:0] I_JAL  = 9'h001;
    localparam logic [8:0] I_JALR = 9'h002;
    localparam logic [8:0] I_BEQ  = 9'h004;
    localparam logic [8:0] I_BLT  = 9'h010;
    localparam logic [8:0] I_BLTU = 9'h040;
    localparam logic [8:0] I_PRD  = 9'h100;

    function automatic res_t model_exec(input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] imm, input logic [31:0] pc,
                                        input logic [8:0] info);
        res_t r;
        int   nbits;
        int   which;
        bit   tk;
        nbits = 0;
        which = -1;
        for (int b = 0; b < 8; b++) begin
            if (info[b]) begin
                nbits++;
                which = b;
            end
        end
        r = '0;
        r.target = pc + 32'd4;
        if (nbits != 1) return r;
        case (which)
            0, 1: tk = 1;
            2: tk = (rs1 == rs2);
            3: tk = (rs1 != rs2);
            4: tk = (int'(rs1) < int'(rs2));
            5: tk = (int'(rs1) >= int'(rs2));
            6: tk = (rs1 < rs2);
            default: tk = (rs1 >= rs2);
        endcase
        r.taken = tk;
        if (tk) r.target = (which == 1) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        if (which <= 1) begin
            r.wen  = 1;
            r.wdat = pc + 32'd4;
        end
        if (which == 1) r.mispred = 1;
        else if (which >= 2) r.mispred = tk ^ info[8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush = 0;
        m_ov    = 0;
        m_res   = '0;
        m_freq  = 0;
        m_fpc   = '0;
        m_cnt   = 0;
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        bit   rdy, acc, hs;
        bit   n_flush, n_ov, n_freq;
        res_t n_res;
        logic [PC_SIZE-1:0] n_fpc;
        int unsigned n_cnt;
        #1;
        if (rst) model_reset();
        rdy = !m_flush && !m_freq && (!m_ov || bjp_o_ready);
        chk("o_valid", 64'(bjp_o_valid), 64'(m_ov));
        chk("flush_req", 64'(flush_req), 64'(m_freq));
        chk("flush_pc", 64'(flush_pc), 64'(m_fpc));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(m_cnt));
        if (!rst) chk("i_ready", 64'(bjp_i_ready), 64'(rdy));
        if (m_ov) begin
            chk("wdat", 64'(bjp_o_wbck_wdat), 64'(m_res.wdat));
            chk("wen", 64'(bjp_o_wbck_en), 64'(m_res.wen));
            chk("taken", 64'(bjp_o_taken), 64'(m_res.taken));
            chk("target", 64'(bjp_o_target), 64'(m_res.target));
            chk("mispred", 64'(bjp_o_mispred), 64'(m_res.mispred));
        end
        acc     = bjp_i_valid && rdy;
        hs      = m_ov && bjp_o_ready;
        n_flush = m_flush;
        n_freq  = m_freq;
        n_fpc   = m_fpc;
        n_cnt   = m_cnt;
        n_ov    = m_ov;
        n_res   = m_res;
        if (!m_flush) begin
            if (hs && m_res.mispred) begin
                n_flush = 1;
                n_freq  = 1;
                n_fpc   = m_res.target;
                if (m_cnt < (2 ** CNT_W) - 1) n_cnt = m_cnt + 1;
            end
        end else if (flush_ack) begin
            n_flush = 0;
            n_freq  = 0;
        end
        if (acc) begin
            n_ov  = 1;
            n_res = model_exec(bjp_i_rs1, bjp_i_rs2, bjp_i_imm, bjp_i_pc, bjp_i_info);
        end else if (hs) begin
            n_ov = 0;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_flush = n_flush;
            m_freq  = n_freq;
            m_fpc   = n_fpc;
            m_cnt   = n_cnt;
            m_ov    = n_ov;
            m_res   = n_res;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [8:0] info, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
        bjp_i_valid = v;
        bjp_i_info  = info;
        bjp_i_rs1   = rs1;
        bjp_i_rs2   = rs2;
        bjp_i_imm   = imm;
        bjp_i_pc    = pc;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 3);
            1: return 32'hFFFF_FFFF - $urandom_range(0, 2);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [8:0]  rinfo;
        logic [31:0] ra, rb;
        int          r;
        int          guard;
        logic [31:0] jpc;

        model_reset();
        rst         = 1'b1;
        bjp_o_ready = 1'b1;
        flush_ack   = 1'b0;
        drive(1'b0, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        cycle();

        // BEQ taken, predicted taken
        drive(1'b1, I_BEQ | I_PRD, 32'd5, 32'd5, 32'h20, 32'h100);
        cycle();
        chk("beq_valid", 64'(bjp_o_valid), 64'd1);
        chk("beq_taken", 64'(bjp_o_taken), 64'd1);
        chk("beq_target", 64'(bjp_o_target), 64'h120);
        chk("beq_mispred", 64'(bjp_o_mispred), 64'd0);
        bjp_i_valid = 1'b0;
        cycle();
        chk("beq_noflush", 64'(flush_req), 64'd0);

        // BLT signed: -1 < 1, predicted not taken -> flush
        drive(1'b1, I_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300);
        cycle();
        chk("blt_taken", 64'(bjp_o_taken), 64'd1);
        chk("blt_mispred", 64'(bjp_o_mispred), 64'd1);
        bjp_i_valid = 1'b0;
        cycle();
        chk("blt_flush_req", 64'(flush_req), 64'd1);
        chk("blt_flush_pc", 64'(flush_pc), 64'h340);
        chk("blt_cnt", 64'(mispred_cnt), 64'd1);
        bjp_i_valid = 1'b1;
        cycle();
        chk("blt_hold_ready", 64'(bjp_i_ready), 64'd0);
        bjp_i_valid = 1'b0;
        flush_ack   = 1'b1;
        cycle();
        flush_ack = 1'b0;
        chk("blt_ack_drop", 64'(flush_req), 64'd0);

        // BLTU same operands: 0xFFFFFFFF < 1 is false
        drive(1'b1, I_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300);
        cycle();
        chk("bltu_taken", 64'(bjp_o_taken), 64'd0);
        chk("bltu_target", 64'(bjp_o_target), 64'h304);
        chk("bltu_mispred", 64'(bjp_o_mispred), 64'd0);
        bjp_i_valid = 1'b0;
        cycle();
        chk("bltu_noflush", 64'(flush_req), 64'd0);

        // JALR link and bit0-cleared target
        drive(1'b1, I_JALR, 32'h1001, 32'h0, 32'd4, 32'h200);
        cycle();
        chk("jalr_wdat", 64'(bjp_o_wbck_wdat), 64'h204);
        chk("jalr_wen", 64'(bjp_o_wbck_en), 64'd1);
        chk("jalr_target", 64'(bjp_o_target), 64'h1004);
        bjp_i_valid = 1'b0;
        cycle();
        chk("jalr_flush", 64'(flush_req), 64'd1);
        chk("jalr_flush_pc", 64'(flush_pc), 64'h1004);
        flush_ack = 1'b1;
        cycle();
        flush_ack = 1'b0;

        // JAL stream with output stalls; inputs advance only when accepted
        jpc = 32'h400;
        for (int i = 0; i < 9; i++) begin
            bjp_o_ready = (i % 3 != 1);
            drive(1'b1, I_JAL, 32'h0, 32'h0, 32'h80, jpc);
            if (!m_flush && (!m_ov || bjp_o_ready)) jpc = jpc + 32'd4;
            cycle();
        end
        bjp_o_ready = 1'b1;
        bjp_i_valid = 1'b0;
        cycle();
        chk("jal_drain", 64'(bjp_o_valid), 64'd0);

        // Drive enough JALRs to saturate the counter
        flush_ack = 1'b1;
        for (int i = 0; i < 3 * (2 ** CNT_W) + 30; i++) begin
            drive(1'b1, I_JALR, 32'(i * 8), 32'h0, 32'h10, 32'(i * 4));
            cycle();
        end
        chk("cnt_saturated", 64'(mispred_cnt), 64'((2 ** CNT_W) - 1));
        flush_ack = 1'b0;
        bjp_i_valid = 1'b0;
        cycle();
        flush_ack = 1'b1;
        cycle();
        flush_ack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) rinfo = 9'(1 << r);
            else if (r == 8) rinfo = 9'h0;
            else rinfo = 9'($urandom);
            rinfo[8] = $urandom_range(0, 1);
            ra = rand_opnd();
            rb = ($urandom_range(0, 3) == 0) ? ra : rand_opnd();
            drive($urandom_range(0, 3) != 0, rinfo, ra, rb, $urandom, $urandom);
            bjp_o_ready = ($urandom_range(0, 9) < 7);
            flush_ack   = ($urandom_range(0, 1) == 1);
            cycle();
        end

        // Reset while a flush is pending
        flush_ack   = 1'b0;
        bjp_o_ready = 1'b1;
        guard       = 0;
        while (!m_freq && guard < 20) begin
            drive(1'b1, I_JALR, 32'h55, 32'h0, 32'h8, 32'h600);
            cycle();
            guard++;
        end
        chk("reached_flush", 64'(m_freq && (guard < 20)), 64'd1);
        bjp_i_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_o_valid", 64'(bjp_o_valid), 64'd0);
        chk("rst_flush_req", 64'(flush_req), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_cnt", 64'(mispred_cnt), 64'd0);
        chk("rst_target", 64'(bjp_o_target), 64'd0);
        chk("rst_wen", 64'(bjp_o_wbck_en), 64'd0);
        cycle();
        rst = 1'b0;
        bjp_i_valid = 1'b0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_bjp_unit.md
Name: exu_bjp_unit

Overview:
- Registered branch/jump execution unit for the EXU.
- Evaluates all RV32I conditional branches plus JAL/JALR, computes the link value and the resolved target, and checks the result against the IFU static prediction.
- Generates a pipeline flush request on misprediction, which the commit/IFU side must acknowledge.
- One output register stage with valid/ready handshakes on both sides; counts mispredictions for performance monitoring.

Parameters:
XLEN, 32, datapath width
PC_SIZE, 32, PC width (PC_SIZE <= XLEN)
CNT_W, 16, width of saturating mispredict counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
bjp_i_valid  in  1  request valid
bjp_i_ready  out  1  request accepted when valid&ready
bjp_i_rs1  in  XLEN  operand 1
bjp_i_rs2  in  XLEN  operand 2
bjp_i_imm  in  XLEN  sign-extended offset
bjp_i_pc  in  PC_SIZE  instruction PC
bjp_i_info  in  DECINFO_BJP_WIDTH  one-hot op {JAL,JALR,BEQ,BNE,BLT,BGE,BLTU,BGEU} plus BPRDT bit
bjp_o_valid  out  1  result valid
bjp_o_ready  in  1  result consumed when valid&ready
bjp_o_wbck_wdat  out  XLEN  link value (pc+4) for JAL/JALR, 0 otherwise
bjp_o_wbck_en  out  1  rd write enable (JAL/JALR)
bjp_o_taken  out  1  resolved taken
bjp_o_target  out  PC_SIZE  resolved next PC
bjp_o_mispred  out  1  result caused a flush
flush_req  out  1  flush request to IFU/commit
flush_pc  out  PC_SIZE  redirect PC
flush_ack  in  1  flush accepted
mispred_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset: state RUN; all outputs 0, including bjp_o_valid, flush_req and mispred_cnt. Reset asserted mid-operation discards the held result and any pending flush.
- Compare: BEQ/BNE on equality; BLT/BGE signed; BLTU/BGEU unsigned; JAL and JALR are always taken.
- Target arithmetic, all sums truncated to PC_SIZE with wrap-around:
  - not taken: pc+4
  - JAL and branches: pc+imm
  - JALR: (rs1+imm) with bit0 cleared
- Link value: pc+4, zero-extended to XLEN.
- Mispredict rules:
  - conditional branch: taken XOR BPRDT
  - JALR: always mispredicts
  - JAL: never mispredicts (IFU resolves it)
- Pipeline register:
  - bjp_i_ready = (state==RUN) && flush_req==0 && (!bjp_o_valid || bjp_o_ready).
  - Accepting a request loads the result one cycle later (latency 1). Back-to-back throughput is 1/cycle while no flush is pending.
  - Output fields hold stable while valid && !ready.
- FSM:
  - RUN → RUN when the output handshake completes with bjp_o_mispred=0.
  - RUN → FLUSH when the output handshake completes with bjp_o_mispred=1. In the same cycle, flush_req←1 and flush_pc←bjp_o_target.
  - FLUSH: flush_req held high, flush_pc stable, bjp_i_ready=0.
  - FLUSH → RUN on flush_ack: flush_req←0. New requests may be accepted from the next cycle.
  - flush_ack while state==RUN is ignored.
- Counter: mispred_cnt increments by 1 on each RUN→FLUSH transition and saturates at all-ones (no wrap).
- Undefined info encodings (zero or multi-hot op bits): treated as not-taken, no writeback, no mispredict.

Decomposition:
- defines.v holds DECINFO_BJP_* field indices and DECINFO_BJP_WIDTH (9).
- The comparator is a natural sub-module, exu_bjp_cmp: combinational eq/lt/ltu and op select, producing taken.
- The top level holds the target adder, output register, FSM and counter.

Test Plan:
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, BPRDT=1 → next cycle valid, taken=1, target=0x120, mispred=0, no flush.
- BLT rs1=0xFFFFFFFF, rs2=1, BPRDT=0 → taken=1 and mispred=1; on handshake, flush_req=1 with flush_pc=pc+imm. i_ready stays 0 until flush_ack, then flush_req drops; mispred_cnt=1.
- BLTU with the same operands, BPRDT=0 → taken=0, target=pc+4, no flush.
- JALR rs1=0x1001, imm=4, pc=0x200 → wdat=0x204, wbck_en=1, target=0x1004, flush asserted.
- Back-to-back JAL stream with bjp_o_ready toggled 1,0,1 → outputs stable during the stall, no request lost or duplicated, throughput 1/cycle when ready=1.
- Reset asserted while in FLUSH, and mispred_cnt forced to saturate at 0xFFFF → all outputs clear on reset; the counter does not wrap.
